sq_wave_seq: RTL and testbench
==============================

// Module: sq_wave_seq
// PURPOSE
// Sequencer for the square-wave generator (4-bit M high / N low time inputs, gen-side reset, sq_wave output).
// Holds a DEPTH-entry table of {M, N, REPEAT} and plays the entries in order.
// Each entry runs for REPEAT full periods, counted on the fed-back sq_wave rising edges; the generator is held in reset between entries.
// Sits between the register/switch front end and the generator instance.
// PARAMETERS
// DEPTH  8  table entries (power of 2, >=2); AW = $clog2(DEPTH) localparam
// RPT_W  8  repeat-count width
// PORTS
// clk         in   1         system clock, all state on rising edge
// reset       in   1         asynchronous, active-low; clears all state
// wr_en       in   1         table write strobe
// wr_addr     in   AW        table write index
// wr_data     in   8+RPT_W   {m[3:0], n[3:0], rep[RPT_W-1:0]}
// start       in   1         begin playback at entry 0 (sampled in IDLE only)
// stop        in   1         abort playback
// loop        in   1         wrap to entry 0 after last entry instead of finishing
// sq_wave_in  in   1         feedback from generator sq_wave
// m_out       out  4         M to generator
// n_out       out  4         N to generator
// gen_rst     out  1         active-high reset to generator/timer/T-FF
// busy        out  1         high in LOAD/RUN
// done        out  1         1-cycle pulse on normal completion
// cur_idx     out  AW        entry currently loaded
// BEHAVIOUR
// - Reset: state IDLE; m_out=0, n_out=0, gen_rst=1, busy=0, done=0, cur_idx=0, rpt_cnt=0, skip_cnt=0; all table entries cleared to 0.
// - Table write: synchronous; accepted in any state. Writing the entry in RUN does not change m_out/n_out until its next LOAD.
// - FSM states: IDLE, LOAD, RUN, DONE.
// - IDLE: gen_rst=1, busy=0. start=1 and stop=0 -> LOAD, cur_idx=0, skip_cnt=0.
// - LOAD (1 cycle): gen_rst=1; m_out/n_out <= table[cur_idx]; rpt_cnt<=0; edge-detect prev<=1 (an already-high output is not an edge).
//   - Entry m=0 and n=0 is a skip: advance as below, skip_cnt+1, no RUN.
//   - Otherwise -> RUN.
// - RUN: gen_rst=0. Rising edge = prev 0, current 1 on registered sq_wave_in.
//   - Each edge: rpt_cnt+1. Target = rep; rep=0 is treated as 1.
//   - Target reached -> advance and clear skip_cnt.
// - Advance: cur_idx<DEPTH-1 -> cur_idx+1, LOAD.
//   - Last entry with loop=1 -> cur_idx=0, LOAD.
//   - Last entry with loop=0 -> DONE.
// - Skip guard: skip_cnt reaches DEPTH (full pass with no playable entry) -> DONE, regardless of loop.
// - DONE (1 cycle): done=1, gen_rst=1 -> IDLE. cur_idx holds its last value.
// - Latency: start sampled on edge t -> LOAD at t+1; m_out valid and gen_rst=0 from t+2.
// - stop: highest priority. In LOAD/RUN/DONE -> IDLE next cycle, gen_rst=1, no done pulse; m_out/n_out hold their value.
// - start while busy: ignored. start+stop in the same IDLE cycle: stays IDLE.
// - rpt_cnt saturates at 2^RPT_W-1; it never wraps.
// - Asynchronous reset mid-operation: all outputs reach their reset values immediately, without waiting for clk.
// CONFIGURATION
// SQ_SEQ_PERIOD_CNT_EN defined:
//   - Adds output period_cnt [15:0]: total rising edges counted in RUN since the last start.
//   - Saturates at 16'hFFFF; cleared by reset and when start is accepted.
// Not defined:
//   - period_cnt port and its counter are absent; all other behaviour is identical.
// TESTING
// 1 Write {3,2,2}@0, {1,1,1}@1, rest 0; loop=0; start -> m_out=3/n_out=2 at t+2; after 2 edges cur_idx=1, m_out=1/n_out=1; after 1 edge entries 2..7 skip, then done=1 for one cycle, gen_rst=1.
// 2 Same table, loop=1 -> cur_idx sequence 0,1,0,1...; never done. Assert stop -> IDLE next cycle, gen_rst=1, done stays 0.
// 3 Entry {2,2,0} -> leaves after exactly 1 rising edge (same as rep=1). Entry {2,2,255} -> 255 edges.
// 4 All-zero table, start -> DEPTH skip LOADs, then done pulse; busy high DEPTH cycles.
// 5 Assert reset low mid-RUN between clk edges -> gen_rst=1, busy=0, m_out=0, cur_idx=0 immediately; table reads back 0.
// 6 start while busy -> no restart, cur_idx unchanged. start+stop in IDLE -> stays IDLE. With SQ_SEQ_PERIOD_CNT_EN, test 1 ends with period_cnt=3.

Source files
------------

// File: rtl/sq_wave_seq_if.sv
// Bus bundle between the sequencer and its front end / generator.
// SQ_SEQ_PERIOD_CNT_EN adds the period_cnt observation signal.
interface sq_wave_seq_if #(
   parameter int AW    = 3,
   parameter int RPT_W = 8
);
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic [8+RPT_W-1:0]   wr_data;
   logic                 start;
   logic                 stop;
   logic                 loop;
   logic                 sq_wave_in;
   logic [3:0]           m_out;
   logic [3:0]           n_out;
   logic                 gen_rst;
   logic                 busy;
   logic                 done;
   logic [AW-1:0]        cur_idx;
`ifdef SQ_SEQ_PERIOD_CNT_EN
   logic [15:0]          period_cnt;
`endif

   modport slave (
      input  wr_en, wr_addr, wr_data, start, stop, loop, sq_wave_in,
      output m_out, n_out, gen_rst, busy, done, cur_idx
`ifdef SQ_SEQ_PERIOD_CNT_EN
      , output period_cnt
`endif
   );

   modport master (
      output wr_en, wr_addr, wr_data, start, stop, loop, sq_wave_in,
      input  m_out, n_out, gen_rst, busy, done, cur_idx
`ifdef SQ_SEQ_PERIOD_CNT_EN
      , input period_cnt
`endif
   );
endinterface

// File: rtl/sq_wave_seq.sv
// Table-driven sequencer for the square-wave generator: plays {M, N, REPEAT} entries in order.
// Define SQ_SEQ_PERIOD_CNT_EN to add the saturating period_cnt output.
module sq_wave_seq #(
   parameter int DEPTH = 8,
   parameter int RPT_W = 8
) (
   input logic          clk,
   input logic          reset,
   sq_wave_seq_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int EW = 8 + RPT_W;
   localparam int SW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [EW-1:0]    tbl_q [DEPTH];
   logic [3:0]       m_q, m_d;
   logic [3:0]       n_q, n_d;
   logic [RPT_W-1:0] rep_q, rep_d;
   logic [RPT_W-1:0] rpt_q, rpt_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [SW-1:0]    skip_q, skip_d;
   logic             sq_q;
   logic             prev_q, prev_d;

   logic [EW-1:0]    entry;
   logic [3:0]       entry_m;
   logic [3:0]       entry_n;
   logic [RPT_W-1:0] entry_rep;
   logic             last_entry;
   logic             wrap_done;
   logic [AW-1:0]    adv_idx;
   logic [RPT_W:0]   rpt_inc;
   logic [RPT_W-1:0] target;
   logic             run_edge;
   logic             start_ok;

   // NOTE: the table is ordinary flops with an async clear, so it resets like every other register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
      end else if (bus.wr_en) begin
         tbl_q[bus.wr_addr] <= bus.wr_data;
      end
   end

   assign entry      = tbl_q[idx_q];
   assign entry_m    = entry[EW-1 -: 4];
   assign entry_n    = entry[EW-5 -: 4];
   assign entry_rep  = entry[RPT_W-1:0];

   assign last_entry = (idx_q == AW'(DEPTH - 1));
   assign wrap_done  = last_entry && !bus.loop;
   assign adv_idx    = last_entry ? (bus.loop ? '0 : idx_q) : idx_q + 1'b1;

   assign rpt_inc    = {1'b0, rpt_q} + 1'b1;
   assign target     = (rep_q == '0) ? RPT_W'(1) : rep_q;
   assign run_edge   = (state_q == S_RUN) && sq_q && !prev_q;
   assign start_ok   = (state_q == S_IDLE) && bus.start && !bus.stop;

   // NOTE: every variable gets its hold value first, so no path leaves one unassigned and no latch appears.
   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      n_d     = n_q;
      rep_d   = rep_q;
      rpt_d   = rpt_q;
      idx_d   = idx_q;
      skip_d  = skip_q;
      prev_d  = prev_q;

      unique case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d = S_LOAD;
               idx_d   = '0;
               skip_d  = '0;
            end
         end
         S_LOAD: begin
            m_d    = entry_m;
            n_d    = entry_n;
            rep_d  = entry_rep;
            rpt_d  = '0;
            prev_d = 1'b1;  // output already high at release must not count as an edge
            if (entry_m == 4'd0 && entry_n == 4'd0) begin
               skip_d = skip_q + 1'b1;
               if (skip_q == SW'(DEPTH - 1) || wrap_done) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_LOAD;
                  idx_d   = adv_idx;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            prev_d = sq_q;
            if (run_edge) begin
               rpt_d = rpt_inc[RPT_W] ? rpt_q : rpt_inc[RPT_W-1:0];
               if (rpt_inc >= {1'b0, target}) begin
                  skip_d  = '0;
                  state_d = wrap_done ? S_DONE : S_LOAD;
                  idx_d   = adv_idx;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort wins over everything; the generator settings stay as they were.
      if (bus.stop && state_q != S_IDLE) begin
         state_d = S_IDLE;
         m_d     = m_q;
         n_d     = n_q;
         idx_d   = idx_q;
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         m_q     <= '0;
         n_q     <= '0;
         rep_q   <= '0;
         rpt_q   <= '0;
         idx_q   <= '0;
         skip_q  <= '0;
         sq_q    <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         n_q     <= n_d;
         rep_q   <= rep_d;
         rpt_q   <= rpt_d;
         idx_q   <= idx_d;
         skip_q  <= skip_d;
         sq_q    <= bus.sq_wave_in;
         prev_q  <= prev_d;
      end
   end

`ifdef SQ_SEQ_PERIOD_CNT_EN
   logic [15:0] pcnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcnt_q <= '0;
      end else if (start_ok) begin
         pcnt_q <= '0;
      end else if (run_edge && pcnt_q != 16'hFFFF) begin
         pcnt_q <= pcnt_q + 1'b1;
      end
   end

   assign bus.period_cnt = pcnt_q;
`endif

   // Status decodes straight from the state register so the async clear reaches them at once.
   assign bus.m_out   = m_q;
   assign bus.n_out   = n_q;
   assign bus.cur_idx = idx_q;
   assign bus.gen_rst = (state_q != S_RUN);
   assign bus.busy    = (state_q == S_LOAD) || (state_q == S_RUN);
   assign bus.done    = (state_q == S_DONE) && !bus.stop;

endmodule

// File: tb/tb_sq_wave_seq.sv
// Scoreboard bench for sq_wave_seq: a behavioural generator closes the sq_wave loop and a
// negedge monitor compares every completed RUN and every done pulse against queued expectations.
`timescale 1ns/1ps
module tb_sq_wave_seq;
   localparam int DEPTH = 8;
   localparam int RPT_W = 8;
   localparam int AW    = 3;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   sq_wave_seq_if #(.AW(AW), .RPT_W(RPT_W)) bus ();

   sq_wave_seq #(.DEPTH(DEPTH), .RPT_W(RPT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Generator model: low N cycles, then high M cycles, repeating; cleared while gen_rst.
   logic       sq   = 1'b0;
   logic [3:0] gcnt = '0;
   always @(posedge clk) begin
      if (bus.gen_rst) begin
         sq   <= 1'b0;
         gcnt <= '0;
      end else if (!sq) begin
         if (gcnt + 1 >= bus.n_out) begin sq <= 1'b1; gcnt <= '0; end
         else gcnt <= gcnt + 1'b1;
      end else begin
         if (gcnt + 1 >= bus.m_out) begin sq <= 1'b0; gcnt <= '0; end
         else gcnt <= gcnt + 1'b1;
      end
   end
   assign bus.sq_wave_in = sq;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   typedef enum int {EV_RUN, EV_DONE} ev_kind_e;
   typedef struct {
      ev_kind_e kind;
      int       idx;
      int       m;
      int       n;
      int       len;
   } ev_t;

   ev_t exp_q[$];

   // Expected RUN length in gen_rst-low cycles: first edge after N, then one per period, plus
   // the input register and the edge-to-LOAD step.
   function automatic int run_len_of(input int m, input int n, input int rep);
      int r;
      r = (rep == 0) ? 1 : rep;
      return n + (r - 1) * (m + n) + 2;
   endfunction

   task automatic exp_run(input int idx, input int m, input int n, input int rep);
      ev_t e;
      e.kind = EV_RUN; e.idx = idx; e.m = m; e.n = n; e.len = run_len_of(m, n, rep);
      exp_q.push_back(e);
   endtask

   task automatic exp_done(input int idx);
      ev_t e;
      e.kind = EV_DONE; e.idx = idx; e.m = 0; e.n = 0; e.len = 0;
      exp_q.push_back(e);
   endtask

   task automatic sb_compare(input ev_t obs);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: got kind %0d idx %0d, expected none", obs.kind, obs.idx);
      end else begin
         e = exp_q.pop_front();
         check("ev_kind", obs.kind, e.kind);
         check("ev_idx", obs.idx, e.idx);
         if (e.kind == EV_RUN) begin
            check("run_m", obs.m, e.m);
            check("run_n", obs.n, e.n);
            check("run_len", obs.len, e.len);
         end
      end
   endtask

   bit   mon_en      = 1'b1;
   int   run_len     = 0;
   int   r_idx       = 0;
   int   r_m         = 0;
   int   r_n         = 0;
   logic gen_rst_prv = 1'b1;

   always @(negedge clk) begin
      ev_t obs;
      if (bus.gen_rst === 1'b0) begin
         run_len++;
         r_idx = int'(bus.cur_idx);
         r_m   = int'(bus.m_out);
         r_n   = int'(bus.n_out);
      end else if (gen_rst_prv === 1'b0) begin
         if (mon_en) begin
            obs.kind = EV_RUN; obs.idx = r_idx; obs.m = r_m; obs.n = r_n; obs.len = run_len;
            sb_compare(obs);
         end
         run_len = 0;
      end
      if (bus.done === 1'b1 && mon_en) begin
         obs.kind = EV_DONE; obs.idx = int'(bus.cur_idx); obs.m = 0; obs.n = 0; obs.len = 0;
         sb_compare(obs);
         check("done_gen_rst", bus.gen_rst, 1);
      end
      gen_rst_prv = bus.gen_rst;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_entry(input int addr, input logic [3:0] m, input logic [3:0] n,
                              input logic [RPT_W-1:0] rep);
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(addr);
      bus.wr_data = {m, n, rep};
      tick();
      bus.wr_en   = 1'b0;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic drain(input int budget, input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check({name, "_pending"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      bit reached;

      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.start   = 1'b0;
      bus.stop    = 1'b0;
      bus.loop    = 1'b0;

      // Reset state
      #12;
      check("rst_gen_rst", bus.gen_rst, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_m_out", bus.m_out, 0);
      check("rst_n_out", bus.n_out, 0);
      check("rst_cur_idx", bus.cur_idx, 0);
      tick();
      reset = 1'b1;
      tick();

      // Two playable entries then six skips, finishing with a done pulse
      write_entry(0, 4'd3, 4'd2, 8'd2);
      write_entry(1, 4'd1, 4'd1, 8'd1);
      bus.loop = 1'b0;
      exp_run(0, 3, 2, 2);
      exp_run(1, 1, 1, 1);
      exp_done(7);
      pulse_start();
      check("t1_load_busy", bus.busy, 1);
      check("t1_load_gen_rst", bus.gen_rst, 1);
      tick();
      check("t1_m_out", bus.m_out, 3);
      check("t1_n_out", bus.n_out, 2);
      check("t1_gen_rst", bus.gen_rst, 0);
      check("t1_cur_idx", bus.cur_idx, 0);
      drain(300, "t1");
`ifdef SQ_SEQ_PERIOD_CNT_EN
      check("t1_period_cnt", bus.period_cnt, 3);
`endif

      // Looping playback, then stop
      bus.loop = 1'b1;
      exp_run(0, 3, 2, 2);
      exp_run(1, 1, 1, 1);
      exp_run(0, 3, 2, 2);
      exp_run(1, 1, 1, 1);
      pulse_start();
      drain(400, "t2");
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      check("t2_stop_busy", bus.busy, 0);
      check("t2_stop_gen_rst", bus.gen_rst, 1);
      check("t2_stop_done", bus.done, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t2_idle_done", bus.done, 0);
      end
      bus.loop = 1'b0;

      // rep=0 plays once; rep=255 plays 255 periods
      write_entry(0, 4'd2, 4'd2, 8'd0);
      write_entry(1, 4'd2, 4'd2, 8'd255);
      exp_run(0, 2, 2, 0);
      exp_run(1, 2, 2, 255);
      exp_done(7);
      pulse_start();
      drain(1500, "t3");

      // All-zero table: DEPTH skip loads then done
      write_entry(0, 4'd0, 4'd0, 8'd0);
      write_entry(1, 4'd0, 4'd0, 8'd0);
      exp_done(7);
      pulse_start();
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.busy !== 1'b1) break;
         cnt++;
         tick();
      end
      check("t4_busy_cycles", cnt, DEPTH);
      drain(20, "t4");

      // Asynchronous reset in the middle of the second entry
      write_entry(0, 4'd1, 4'd1, 8'd1);
      write_entry(1, 4'd3, 4'd2, 8'd4);
      mon_en = 1'b0;
      pulse_start();
      reached = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (bus.cur_idx == AW'(1) && bus.gen_rst == 1'b0) begin
            reached = 1'b1;
            break;
         end
         tick();
      end
      check("t5_reach_run", reached, 1);
      tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      check("t5_async_gen_rst", bus.gen_rst, 1);
      check("t5_async_busy", bus.busy, 0);
      check("t5_async_m_out", bus.m_out, 0);
      check("t5_async_n_out", bus.n_out, 0);
      check("t5_async_cur_idx", bus.cur_idx, 0);
      tick();
      reset = 1'b1;
      tick();
      mon_en = 1'b1;
      exp_done(7);
      pulse_start();
      drain(40, "t5_table_cleared");

      // start while busy is ignored
      write_entry(0, 4'd3, 4'd3, 8'd3);
      exp_run(0, 3, 3, 3);
      exp_done(7);
      pulse_start();
      repeat (5) tick();
      pulse_start();
      check("t6_restart_idx", bus.cur_idx, 0);
      check("t6_restart_busy", bus.busy, 1);
      drain(100, "t6");

      // start together with stop in IDLE stays IDLE
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      check("t6_ss_busy", bus.busy, 0);
      check("t6_ss_gen_rst", bus.gen_rst, 1);
      tick();
      check("t6_ss_busy_later", bus.busy, 0);

      // stop during RUN: next cycle idle, settings held, no done
      mon_en = 1'b0;
      pulse_start();
      repeat (4) tick();
      check("t6_in_run", bus.gen_rst, 0);
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
      check("t6_stop_busy", bus.busy, 0);
      check("t6_stop_gen_rst", bus.gen_rst, 1);
      check("t6_stop_done", bus.done, 0);
      check("t6_stop_m_hold", bus.m_out, 3);
      check("t6_stop_n_hold", bus.n_out, 3);
      tick();
      check("t6_stop_done_later", bus.done, 0);
      mon_en = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
